key_debounce: RTL and testbench

- Debounces one raw mechanical push-button input (S3 and similar keys).
- Emits a clean debounced level, a one-cycle press strobe and a one-cycle release strobe.
- Sits directly upstream of the BCD key counter; `key_press` drives the counter's increment input in place of the raw key.
- Edge detection in the consumer becomes unnecessary, and contact bounce no longer causes multiple counts.

---
 rtl/key_debounce.sv | 107 ++++++++++
 tb/tb_key_debounce.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state qualifier that
// emits a clean level plus one-cycle press/release strobes once the key has settled.
module key_debounce #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int KEY_ACTIVE  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int DB_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
    localparam int CW        = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic IDLE_LVL = (KEY_ACTIVE == 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    generate
        if (DB_CYCLES < 2 || DB_CYCLES > (1 << 24)) begin : g_bad_cfg
            $error("key_debounce: DB_CYCLES out of range 2..2^24");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state_q;
    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          key_on;

    // Normalised so the FSM always works in "1 = pressed" terms.
    assign key_on = (sync2_q != IDLE_LVL);
    assign cnt_d  = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= IDLE_LVL;
            sync2_q     <= IDLE_LVL;
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1_q     <= key_in;
            sync2_q     <= sync1_q;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_on) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_on) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= PRESSED;
                        cnt_q     <= '0;
                        key_level <= 1'b1;
                        key_press <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                PRESSED: begin
                    if (!key_on) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // Any pressed sample here is bounce: fall back without a strobe.
                    if (key_on) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        key_level   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: active-high and active-low instances share one stimulus;
// a run-length reference model feeds a scoreboard queue checked by a separate monitor.
module tb_key_debounce;

    localparam int DB = 10;

    logic clk;
    logic rst_n;
    logic key_raw;
    logic key_n;
    logic hi_level, hi_press, hi_release;
    logic lo_level, lo_press, lo_release;

    assign key_n = ~key_raw;

    key_debounce #(.CLK_FREQ_HZ(1000), .DEBOUNCE_MS(10), .KEY_ACTIVE(1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .key_in(key_raw),
        .key_level(hi_level), .key_press(hi_press), .key_release(hi_release)
    );

    key_debounce #(.CLK_FREQ_HZ(1000), .DEBOUNCE_MS(10), .KEY_ACTIVE(0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .key_in(key_n),
        .key_level(lo_level), .key_press(lo_press), .key_release(lo_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual{lvl,prs,rel}=%b required=%b", name, $time, act, exp);
        end
    endtask

    task automatic check_n(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: the raw level reaches the decision point two edges late; the
    // debounced level flips once DB+1 consecutive samples disagree with it.
    logic [2:0] exp_q[$];
    logic m_s0, m_s1, m_lvl;
    int   m_run;

    always @(posedge clk) begin
        logic       k;
        logic [2:0] e;
        if (!rst_n) begin
            m_s0  = 1'b0;
            m_s1  = 1'b0;
            m_lvl = 1'b0;
            m_run = 0;
            e     = 3'b000;
        end else begin
            k    = m_s1;
            m_s1 = m_s0;
            m_s0 = key_raw;
            e    = 3'b000;
            m_run = (k != m_lvl) ? m_run + 1 : 0;
            if (m_run == DB + 1) begin
                m_lvl = ~m_lvl;
                m_run = 0;
                e[1]  = m_lvl;
                e[0]  = ~m_lvl;
            end
            e[2] = m_lvl;
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!rst_n) e = 3'b000;
            check("sb_hi", {hi_level, hi_press, hi_release}, e);
            check("sb_lo", {lo_level, lo_press, lo_release}, e);
        end
    end

    // Downstream BCD key counter driven by the active-low instance's press strobe.
    logic [7:0] bcd;
    logic       bcd_clr;
    always @(posedge clk) begin
        if (bcd_clr) bcd <= 8'h00;
        else if (lo_press) begin
            if (bcd[3:0] == 4'd9) bcd <= {bcd[7:4] + 4'd1, 4'd0};
            else bcd <= {bcd[7:4], bcd[3:0] + 4'd1};
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Counts edges from the current stimulus change until the strobe appears.
    task automatic expect_strobe(input string name, input bit want_press);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            seen = want_press ? hi_press : hi_release;
        end
        #1;
        check_n(name, seen ? n : -1, DB + 3);
    endtask

    initial begin
        rst_n   = 1'b0;
        key_raw = 1'b0;
        bcd_clr = 1'b1;
        step(3);
        check("reset_hi", {hi_level, hi_press, hi_release}, 3'b000);
        check("reset_lo", {lo_level, lo_press, lo_release}, 3'b000);
        rst_n = 1'b1;
        step(5);

        key_raw = 1'b1;
        expect_strobe("clean_press_latency", 1'b1);
        check_n("clean_press_level", hi_level, 1);
        step(27);

        key_raw = 1'b0;
        step(5);
        key_raw = 1'b1;
        step(20);
        check_n("glitch0_keeps_level", hi_level, 1);
        key_raw = 1'b0;
        expect_strobe("release_latency", 1'b0);
        check_n("release_level", hi_level, 0);
        step(10);

        for (int i = 0; i < 10; i++) begin
            key_raw = (i % 2 == 0);
            step(3);
        end
        key_raw = 1'b1;
        expect_strobe("bounce_press_latency", 1'b1);
        key_raw = 1'b0;
        step(20);

        key_raw = 1'b1;
        step(9);
        key_raw = 1'b0;
        step(20);
        check_n("short_pulse_level", hi_level, 0);

        key_raw = 1'b1;
        step(8);
        rst_n = 1'b0;
        #1;
        check("rst_mid_qual", {hi_level, hi_press, hi_release}, 3'b000);
        step(2);
        rst_n = 1'b1;
        expect_strobe("post_reset_press", 1'b1);
        step(5);
        rst_n = 1'b0;
        #1;
        check("rst_while_pressed_hi", {hi_level, hi_press, hi_release}, 3'b000);
        check("rst_while_pressed_lo", {lo_level, lo_press, lo_release}, 3'b000);
        key_raw = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(5);

        bcd_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_raw = 1'b1;
            step(15);
            key_raw = 1'b0;
            step(15);
        end
        check_n("bcd_count", int'(bcd), 16);
        bcd_clr = 1'b1;

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                step($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            key_raw = 1'($urandom_range(0, 1));
            step($urandom_range(1, 24));
        end
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
